// File: rtl/calc_pkg.sv
// Shared definitions for the hex calculator controller:
// key codes, operator and FSM state encodings.
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'd16;
    localparam logic [4:0] KEY_SUB = 5'd17;
    localparam logic [4:0] KEY_MUL = 5'd18;
    localparam logic [4:0] KEY_EQU = 5'd19;
    localparam logic [4:0] KEY_CLR = 5'd20;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_A   = 3'd1,
        S_GET_B   = 3'd2,
        S_COMPUTE = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    function automatic logic is_op_key(input logic [4:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL);
    endfunction

    function automatic op_t key_to_op(input logic [4:0] code);
        op_t o;
        case (code)
            KEY_SUB: o = OP_SUB;
            KEY_MUL: o = OP_MUL;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one bit of b per cycle, W-cycle latency.
// Ports: clk, rst (async high), start (load a/b), a, b in;
//        done (last iteration cycle), low (low W bits), overflow (high half != 0).
module seq_mult
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] low,
    output logic         overflow
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc_next;

    // Outputs expose the value the accumulator takes on the final edge,
    // so the controller can capture the product on the same edge.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = (cnt == CW'(1));
    assign low      = acc_next[W-1:0];
    assign overflow = |acc_next[2*W-1:W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(W);
        end else if (cnt != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Hex keypad calculator controller: collects two operands, runs ADD/SUB/MUL.
// Ports: clk, rst (async high), key_valid, key_code[4:0] in;
//        disp_data[W-1:0], disp_start, result_valid, overflow, busy out.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [4:0]   key_code,
    output logic [W-1:0] disp_data,
    output logic         disp_start,
    output logic         result_valid,
    output logic         overflow,
    output logic         busy
);

    state_t       state;
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;

    // Accepted key is registered once; the FSM acts on it the next cycle.
    logic         kv_q;
    logic [4:0]   kc_q;

    logic         k_digit;
    logic         k_op;
    logic         k_equ;
    logic         k_clr;
    logic [3:0]   digit;

    logic [W:0]   sum;
    logic [W:0]   diff;

    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_low;
    logic         mul_ovf;

    function automatic logic [W-1:0] shift_in(input logic [W-1:0] x,
                                              input logic [3:0]   d);
        logic [W+3:0] t;
        t = {x, d};
        return t[W-1:0];
    endfunction

    assign busy       = (state == S_COMPUTE);
    assign disp_start = (state != S_IDLE);

    assign k_digit = kv_q && !kc_q[4];
    assign k_op    = kv_q && is_op_key(kc_q);
    assign k_equ   = kv_q && (kc_q == KEY_EQU);
    assign k_clr   = kv_q && (kc_q == KEY_CLR);
    assign digit   = kc_q[3:0];

    // Extra top bit is the carry-out for ADD and the borrow for SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    assign mul_start = (state == S_GET_B) && k_equ && (op == OP_MUL);

    seq_mult #(.W(W)) u_mult (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .a        (a),
        .b        (b),
        .done     (mul_done),
        .low      (mul_low),
        .overflow (mul_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kv_q <= 1'b0;
            kc_q <= '0;
        end else begin
            kv_q <= key_valid && !busy && (key_code <= KEY_CLR);
            kc_q <= key_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            op           <= OP_ADD;
            a            <= '0;
            b            <= '0;
            result       <= '0;
            disp_data    <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (k_clr && state != S_COMPUTE) begin
                state     <= S_IDLE;
                a         <= '0;
                b         <= '0;
                result    <= '0;
                disp_data <= '0;
                overflow  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (k_digit) begin
                            a         <= W'(digit);
                            disp_data <= W'(digit);
                            state     <= S_GET_A;
                        end
                    end
                    S_GET_A: begin
                        if (k_digit) begin
                            a         <= shift_in(a, digit);
                            disp_data <= shift_in(a, digit);
                        end else if (k_op) begin
                            op        <= key_to_op(kc_q);
                            b         <= '0;
                            disp_data <= '0;
                            state     <= S_GET_B;
                        end
                    end
                    S_GET_B: begin
                        if (k_digit) begin
                            b         <= shift_in(b, digit);
                            disp_data <= shift_in(b, digit);
                        end else if (k_op) begin
                            op <= key_to_op(kc_q);
                        end else if (k_equ) begin
                            state <= S_COMPUTE;
                        end
                    end
                    S_COMPUTE: begin
                        if (op == OP_MUL) begin
                            if (mul_done) begin
                                result       <= mul_low;
                                overflow     <= mul_ovf;
                                disp_data    <= mul_low;
                                result_valid <= 1'b1;
                                state        <= S_SHOW;
                            end
                        end else begin
                            result       <= (op == OP_SUB) ? diff[W-1:0] : sum[W-1:0];
                            overflow     <= (op == OP_SUB) ? diff[W] : sum[W];
                            disp_data    <= (op == OP_SUB) ? diff[W-1:0] : sum[W-1:0];
                            result_valid <= 1'b1;
                            state        <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (k_digit) begin
                            a         <= W'(digit);
                            disp_data <= W'(digit);
                            overflow  <= 1'b0;
                            state     <= S_GET_A;
                        end else if (k_op) begin
                            // Chain: previous result becomes the left operand.
                            a         <= result;
                            op        <= key_to_op(kc_q);
                            b         <= '0;
                            disp_data <= '0;
                            state     <= S_GET_B;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter: W, 8, operand/result width in bits; SHALL be a multiple of 4, range 4..16.
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: key_valid  in  1  one-cycle strobe, key_code valid.
REQ-005 Port: key_code  in  5  0-15 hex digit; 16 ADD, 17 SUB, 18 MUL, 19 EQU, 20 CLR; 21-31 ignored.
REQ-006 Port: disp_data  out  W  value for the downstream 7-segment display stage.
REQ-007 Port: disp_start  out  1  display enable for the downstream stage.
REQ-008 Port: result_valid  out  1  one-cycle pulse, new result on disp_data.
REQ-009 Port: overflow  out  1  last result out of W-bit range.
REQ-010 Port: busy  out  1  computation in progress; keys ignored.

Function
REQ-011 A key SHALL be accepted on a rising edge with key_valid=1, busy=0 and key_code<=20; all other keys SHALL be dropped without effect.
REQ-012 States SHALL be IDLE, GET_A, GET_B, COMPUTE, SHOW.
REQ-013 IDLE: digit d -> GET_A, A=d; other keys are ignored.
REQ-014 GET_A/GET_B digit d: operand = {operand[W-5:0], d}, shift-in on the right, oldest nibble dropped.
REQ-015 GET_A: ADD/SUB/MUL -> store op, B=0, go GET_B; EQU is ignored.
REQ-016 GET_B: ADD/SUB/MUL -> replace stored op, B unchanged; EQU -> COMPUTE.
REQ-017 ADD: result = (A+B) mod 2^W; overflow = carry-out.
REQ-018 SUB: result = (A-B) mod 2^W; overflow = borrow (A<B unsigned).
REQ-019 MUL: iterative shift-add, one bit of B per cycle; result = low W bits; overflow = high W bits nonzero.
REQ-020 Latency: EQU accepted at edge k; ADD/SUB result registered and SHOW entered at edge k+2; MUL at edge k+1+W.
REQ-021 result_valid SHALL be 1 for exactly the first cycle in SHOW.
REQ-022 busy SHALL be 1 exactly while state=COMPUTE.
REQ-023 SHOW: digit d -> GET_A, A=d, overflow cleared; operator -> A=result, store op, B=0, GET_B (chaining); EQU is ignored.
REQ-024 CLR in IDLE/GET_A/GET_B/SHOW -> IDLE, A=B=result=0, overflow=0; CLR during COMPUTE is dropped per REQ-011.
REQ-025 disp_data: IDLE 0; GET_A A; GET_B B; COMPUTE holds last displayed value; SHOW result.
REQ-026 disp_start SHALL be 1 in every state except IDLE.
REQ-027 Codes 21-31 SHALL NOT alter state, operands or outputs.

Reset
REQ-028 rst SHALL asynchronously force IDLE, A=B=result=0, op=ADD, and the multiplier counter to 0.
REQ-029 Outputs under reset: disp_data=0, disp_start=0, result_valid=0, overflow=0, busy=0.
REQ-030 Reset asserted mid-COMPUTE SHALL abort the computation; no result_valid pulse after release.

Structure
REQ-031 Shared package calc_pkg SHALL hold the key-code constants, op enum (ADD/SUB/MUL) and state enum.
REQ-032 The multiplier SHALL be a sub-module seq_mult (start, A, B -> done, W-bit low, overflow), W-cycle latency.
REQ-033 ADD/SUB SHALL be combinational inside calc_ctrl and registered on COMPUTE exit.

Verification
REQ-034 Keys 3,A,ADD,0,5,EQU -> disp_data 0x3A then 0x05; result 0x3F with result_valid pulse 2 cycles after EQU; overflow=0.
REQ-035 Keys F,0,ADD,2,0,EQU -> result 0x10, overflow=1; then digit 7 -> disp_data 0x07, overflow=0.
REQ-036 Keys 1,0,MUL,1,2,EQU -> busy high 8 cycles, result 0x20, overflow=1 (0x120); keys sent while busy have no effect.
REQ-037 Keys 0,5,SUB,0,7,EQU -> result 0xFE, overflow=1; then MUL,2,EQU -> result 0xFC, overflow=1.
REQ-038 Keys 1,2,3 -> disp_data 0x23; CLR -> disp_data 0, disp_start 0; code 25 in any state -> no change.
REQ-039 rst pulsed 3 cycles after MUL EQU -> all outputs 0 immediately, IDLE, no result_valid after release.
